// File: rtl/vga_sync_monitor.sv
// VGA sync monitor: measures line/frame timing, tracks active-video position and locks onto stable timing.
// Optional `SYNC_MON_TIMEOUT_EN adds an HSync-loss timeout (HCnt saturates at 1023).
module vga_sync_monitor #(
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_hsync,
    input  logic       i_vsync,
    input  logic       i_blank,
    output logic [9:0] o_pos_x,
    output logic [9:0] o_pos_y,
    output logic       o_active,
    output logic [9:0] o_line_len,
    output logic [9:0] o_frame_lines,
    output logic       o_locked,
    output logic       o_err
);

    localparam logic [1:0] S_SEARCH  = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_VERIFY  = 2'd2;
    localparam logic [1:0] S_LOCKED  = 2'd3;

    logic       r_hs1, r_hs2, r_vs1, r_vs2, r_bl1, r_bl2;
    logic [9:0] r_hcnt, r_vcnt, r_line, r_ref;
    logic [9:0] r_line_len, r_frame_lines, r_pos_x, r_pos_y;
    logic       r_active, r_err, r_dirty, r_len_valid;
    logic [1:0] r_state;

    logic       w_hs_edge, w_vs_edge, w_line_mis, w_dirty, w_timeout;
    logic       w_err_nxt;
    logic [1:0] w_state_nxt;
    logic [9:0] w_hcnt_inc, w_frame_nxt, w_line_nxt;

    assign w_hs_edge   = (r_hs1 == HSYNC_POL) && (r_hs2 != HSYNC_POL);
    assign w_vs_edge   = (r_vs1 == VSYNC_POL) && (r_vs2 != VSYNC_POL);
    assign w_hcnt_inc  = r_hcnt + 10'd1;
    // The first line after leaving SEARCH may be partial, so r_len_valid masks it
    assign w_line_mis  = w_hs_edge && r_len_valid && (w_hcnt_inc != r_line_len);
    assign w_dirty     = r_dirty | w_line_mis;
    assign w_frame_nxt = w_hs_edge ? (r_vcnt + 10'd1) : r_vcnt;
    assign w_line_nxt  = w_vs_edge ? 10'd0 : ((r_bl1 && !r_bl2) ? (r_line + 10'd1) : r_line);

`ifdef SYNC_MON_TIMEOUT_EN
    assign w_timeout = !w_hs_edge && (r_hcnt == 10'd1022);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_SEARCH:  if (w_vs_edge) w_state_nxt = S_MEASURE;
            S_MEASURE: if (w_vs_edge && !w_dirty) w_state_nxt = S_VERIFY;
            S_VERIFY: begin
                if (w_vs_edge)
                    w_state_nxt = (!w_dirty && (w_frame_nxt == r_ref)) ? S_LOCKED : S_MEASURE;
            end
            S_LOCKED: begin
                if (w_line_mis || (w_vs_edge && (w_frame_nxt != r_ref))) begin
                    w_state_nxt = S_SEARCH;
                    w_err_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = S_SEARCH;
        endcase
        if (w_timeout) begin
            w_state_nxt = S_SEARCH;
            w_err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hs1         <= 1'b0;
            r_hs2         <= 1'b0;
            r_vs1         <= 1'b0;
            r_vs2         <= 1'b0;
            r_bl1         <= 1'b0;
            r_bl2         <= 1'b0;
            r_hcnt        <= 10'd0;
            r_vcnt        <= 10'd0;
            r_line        <= 10'd0;
            r_ref         <= 10'd0;
            r_line_len    <= 10'd0;
            r_frame_lines <= 10'd0;
            r_pos_x       <= 10'd0;
            r_pos_y       <= 10'd0;
            r_active      <= 1'b0;
            r_err         <= 1'b0;
            r_dirty       <= 1'b0;
            r_len_valid   <= 1'b0;
            r_state       <= S_SEARCH;
        end else begin
            r_hs1 <= i_hsync;
            r_hs2 <= r_hs1;
            r_vs1 <= i_vsync;
            r_vs2 <= r_vs1;
            r_bl1 <= i_blank;
            r_bl2 <= r_bl1;

            if (w_hs_edge) begin
                r_hcnt     <= 10'd0;
                r_line_len <= w_hcnt_inc;
            end else begin
`ifdef SYNC_MON_TIMEOUT_EN
                if (r_hcnt != 10'd1023) r_hcnt <= w_hcnt_inc;
`else
                r_hcnt <= w_hcnt_inc;
`endif
            end

            if (w_vs_edge) begin
                r_vcnt        <= 10'd0;
                r_frame_lines <= w_frame_nxt;
                r_dirty       <= 1'b0;
            end else begin
                if (w_hs_edge)  r_vcnt  <= r_vcnt + 10'd1;
                if (w_line_mis) r_dirty <= 1'b1;
            end

            if (r_state == S_MEASURE && w_vs_edge && !w_dirty)
                r_ref <= w_frame_nxt;

            if (r_state == S_SEARCH || w_state_nxt == S_SEARCH)
                r_len_valid <= 1'b0;
            else if (w_hs_edge)
                r_len_valid <= 1'b1;

            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;

            r_pos_x  <= (r_bl1 || r_bl2) ? 10'd0 : (r_pos_x + 10'd1);
            r_line   <= w_line_nxt;
            r_pos_y  <= r_bl1 ? 10'd0 : w_line_nxt;
            r_active <= ~r_bl1;
        end
    end

    assign o_pos_x       = r_pos_x;
    assign o_pos_y       = r_pos_y;
    assign o_active      = r_active;
    assign o_line_len    = r_line_len;
    assign o_frame_lines = r_frame_lines;
    assign o_locked      = (r_state == S_LOCKED);
    assign o_err         = r_err;

endmodule
